// File: rtl/pipe_scheduler.sv
// Side-scrolling pipe scheduler: three pipe slots, spawn spacing, retirement, scoring and an LFSR for gap heights.
// Optional macro PIPE_SCHED_SPEEDUP_EN: scroll speed grows with score (SPEED + score/8, capped at 4).
module pipe_scheduler #(
    parameter int SCREEN_W = 640,
    parameter int PIPE_W   = 52,
    parameter int SPACING  = 220,
    parameter int GAP_MIN  = 60,
    parameter int SPEED    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        game_en,
    input  logic        frame_tick,
    input  logic [9:0]  bird_x,
    output logic [9:0]  pipe_x0,
    output logic [9:0]  pipe_x1,
    output logic [9:0]  pipe_x2,
    output logic [9:0]  gap_y0,
    output logic [9:0]  gap_y1,
    output logic [9:0]  gap_y2,
    output logic [2:0]  pipe_active,
    output logic [13:0] score,
    output logic        score_pulse,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_FREEZE = 2'b10
    } state_t;

    localparam int CNT_W = 12;
    localparam logic [CNT_W-1:0] L_SPACING = CNT_W'(SPACING);
    localparam logic [9:0]       L_SCREEN  = 10'(SCREEN_W);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [9:0]        r_px [3];
    logic [9:0]        r_gy [3];
    logic [2:0]        r_act;
    logic [2:0]        r_passed;
    logic [CNT_W-1:0]  r_cnt;
    logic [13:0]       r_score;
    logic              r_pulse;
    logic [9:0]        r_lfsr;

    logic [9:0]        w_px [3];
    logic [9:0]        w_gy [3];
    logic [2:0]        w_act;
    logic [2:0]        w_passed;
    logic [CNT_W-1:0]  w_cnt;
    logic [CNT_W-1:0]  w_cnt_sum;
    logic              w_point;
    logic              w_spawned;
    logic [2:0]        w_speed;
    logic [9:0]        w_gap_new;

`ifdef PIPE_SCHED_SPEEDUP_EN
    logic [13:0] w_speed_raw;
    assign w_speed_raw = 14'(SPEED) + {3'b000, r_score[13:3]};
    assign w_speed     = (w_speed_raw > 14'd4) ? 3'd4 : w_speed_raw[2:0];
`else
    assign w_speed = 3'(SPEED);
`endif

    assign w_gap_new = 10'(GAP_MIN) + {2'b00, r_lfsr[7:0]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!clear && game_en) w_state_nxt = S_RUN;
            S_RUN:    if (clear) w_state_nxt = S_IDLE;
                      else if (!game_en) w_state_nxt = S_FREEZE;
            S_FREEZE: if (clear) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Passing is judged on the registered positions; the tick update below
    // runs afterwards so a freshly spawned slot always starts unpassed.
    always_comb begin
        w_px      = r_px;
        w_gy      = r_gy;
        w_act     = r_act;
        w_passed  = r_passed;
        w_cnt     = r_cnt;
        w_cnt_sum = r_cnt + {9'd0, w_speed};
        w_point   = 1'b0;
        w_spawned = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (r_act[i] && !r_passed[i] && !w_point &&
                (({1'b0, r_px[i]} + 11'(PIPE_W)) < {1'b0, bird_x})) begin
                w_passed[i] = 1'b1;
                w_point     = 1'b1;
            end
        end
        if (frame_tick) begin
            for (int i = 0; i < 3; i++) begin
                if (r_act[i]) begin
                    if (r_px[i] < {7'd0, w_speed}) begin
                        w_act[i] = 1'b0;
                        w_px[i]  = 10'd0;
                        w_gy[i]  = 10'd0;
                    end else begin
                        w_px[i] = r_px[i] - {7'd0, w_speed};
                    end
                end
            end
            if (w_cnt_sum >= L_SPACING) begin
                for (int i = 0; i < 3; i++) begin
                    if (!w_act[i] && !w_spawned) begin
                        w_act[i]    = 1'b1;
                        w_px[i]     = L_SCREEN;
                        w_gy[i]     = w_gap_new;
                        w_passed[i] = 1'b0;
                        w_spawned   = 1'b1;
                    end
                end
                // No free slot: park at SPACING so the next tick retries.
                w_cnt = w_spawned ? '0 : L_SPACING;
            end else begin
                w_cnt = w_cnt_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_act    <= '0;
            r_passed <= '0;
            r_cnt    <= L_SPACING;
            r_score  <= '0;
            r_pulse  <= 1'b0;
            r_lfsr   <= 10'h2A5;
            for (int i = 0; i < 3; i++) begin
                r_px[i] <= '0;
                r_gy[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
            r_pulse <= 1'b0;
            if (clear || r_state == S_IDLE) begin
                r_act    <= '0;
                r_passed <= '0;
                r_cnt    <= L_SPACING;
                r_score  <= '0;
                for (int i = 0; i < 3; i++) begin
                    r_px[i] <= '0;
                    r_gy[i] <= '0;
                end
            end else if (r_state == S_RUN) begin
                r_px     <= w_px;
                r_gy     <= w_gy;
                r_act    <= w_act;
                r_passed <= w_passed;
                r_cnt    <= w_cnt;
                if (w_point && r_score != 14'd9999) begin
                    r_score <= r_score + 14'd1;
                    r_pulse <= 1'b1;
                end
            end
        end
    end

    assign pipe_x0     = r_px[0];
    assign pipe_x1     = r_px[1];
    assign pipe_x2     = r_px[2];
    assign gap_y0      = r_gy[0];
    assign gap_y1      = r_gy[1];
    assign gap_y2      = r_gy[2];
    assign pipe_active = r_act;
    assign score       = r_score;
    assign score_pulse = r_pulse;
    assign state       = r_state;

endmodule

// File: doc/pipe_scheduler.md
PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, spawn x-coordinate (left edge of new pipe).
REQ-002 SHALL have parameter PIPE_W, default 52, pipe width in pixels.
REQ-003 SHALL have parameter SPACING, default 220, horizontal pixels travelled between spawns.
REQ-004 SHALL have parameter GAP_MIN, default 60, minimum gap top y.
REQ-005 SHALL have parameter SPEED, default 1, pixels moved per frame_tick.
REQ-006 SHALL have ports: clk input 1 system clock; reset_n input 1 asynchronous active-low reset.
REQ-007 SHALL have ports: clear input 1 synchronous re-init pulse; game_en input 1 playing mode; frame_tick input 1 one-cycle pulse per video frame.
REQ-008 SHALL have ports: bird_x input 10 bird left edge.
REQ-009 SHALL have ports: pipe_x0/1/2 output 10 each, pipe left edge; gap_y0/1/2 output 10 each, gap top y.
REQ-010 SHALL have ports: pipe_active output 3 slot-valid flags; score output 14 pipes passed; score_pulse output 1 one-cycle pulse per point; state output 2.

Function
REQ-011 SHALL implement FSM IDLE(00) -> RUN(01) when game_en=1; RUN -> FREEZE(10) when game_en=0; FREEZE and RUN -> IDLE on clear=1 (clear has priority over all other events).
REQ-012 SHALL, on IDLE entry or in IDLE, hold pipe_active=000, score=0, spawn distance counter=SPACING, so first spawn occurs on the first frame_tick in RUN.
REQ-013 SHALL process a frame_tick only in RUN; frame_tick in IDLE/FREEZE ignored, all positions held.
REQ-014 SHALL, per processed tick, decrement each active pipe_x by current speed; a pipe with pipe_x < speed is retired (active cleared) instead of decremented.
REQ-015 SHALL, per processed tick, add speed to spawn counter; when counter >= SPACING, spawn into lowest-index inactive slot: pipe_x=SCREEN_W, gap_y=GAP_MIN+lfsr[7:0] (range 60..315), passed flag cleared, counter reset to 0.
REQ-016 SHALL evaluate retirement before spawning, so a slot freed on a tick is usable on the same tick.
REQ-017 SHALL, if no slot is free when spawn is due, skip spawn and hold counter at SPACING (retry next tick).
REQ-018 SHALL update all tick-driven outputs on the clock edge that samples frame_tick=1 (latency 1 cycle).
REQ-019 SHALL, every cycle in RUN, mark an active unpassed pipe passed when pipe_x+PIPE_W < bird_x (11-bit compare, no wrap), incrementing score by 1 and asserting score_pulse for that cycle.
REQ-020 SHALL, if multiple pipes pass in one cycle, add only one point that cycle; remaining pipes pass on subsequent cycles.
REQ-021 SHALL saturate score at 9999.
REQ-022 SHALL run a 10-bit Fibonacci LFSR (taps 10,7) advancing every clock in all states; never all-zero.
REQ-023 SHALL keep pipe_x/gap_y of inactive slots at 0.

Reset
REQ-024 SHALL, on reset_n=0, asynchronously force state=IDLE, pipe_active=000, all pipe_x/gap_y=0, score=0, score_pulse=0, counter=SPACING, LFSR=10'h2A5.
REQ-025 SHALL resume from IDLE on the first clock after reset_n deasserts; reset mid-RUN discards all pipes and score.

Configuration
REQ-026 SHALL, with macro PIPE_SCHED_SPEEDUP_EN defined, use speed = SPEED + floor(score/8), capped at 4, recomputed each cycle.
REQ-027 SHALL, without PIPE_SCHED_SPEEDUP_EN, use constant speed = SPEED; no speedup logic synthesized.

Verification
REQ-028 Reset then game_en=1, one frame_tick -> pipe_active=001, pipe_x0=640, gap_y0 in 60..315, state=01.
REQ-029 RUN, 220 further ticks, SPEED=1 -> pipe_x0=420, slot1 spawned at 640, pipe_active=011.
REQ-030 bird_x=100, pipe0 driven to pipe_x=47 -> score 0->1, single score_pulse, no second point on later ticks.
REQ-031 pipe_x0=0 on tick -> slot0 retired; with spawn due same tick and slots 1,2 active -> new pipe in slot0 at 640.
REQ-032 game_en=0 mid-RUN, 10 ticks -> state=10, all outputs unchanged; clear=1 -> state=00, pipe_active=000, score=0.
REQ-033 PIPE_SCHED_SPEEDUP_EN defined, score reaches 8 -> per-tick decrement becomes 2; score 24+ -> decrement 4.
